// File: rtl/cpu_boot_pkg.sv
// cpu_boot_pkg
//   Shared definitions for the cpu_boot_monitor block: controller state
//   encoding and the default width constants used as parameter defaults.
package cpu_boot_pkg;

    localparam int unsigned DW_DEF   = 32;   // data / instruction word width
    localparam int unsigned AW_DEF   = 10;   // memory address width
    localparam int unsigned RW_DEF   = 5;    // register-file address width
    localparam int unsigned NREG_DEF = 10;   // registers dumped per session
    localparam int unsigned TMO_DEF  = 750;  // run-cycle limit

    // Session sequencing; the encoding is visible on debug taps, keep it fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DREQ = 3'd3,
        ST_DOUT = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Width needed to hold the values 0..n inclusive (never less than 1).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cpu_boot_dump_sreg.sv
// cpu_boot_dump_sreg
//   Output holding register for the dump port. While en_i is high a word is
//   offered (valid_o=1). On the first offered cycle the word is passed
//   straight through from d_i and captured; if the consumer stalls, the
//   captured copy is presented until the handshake, so data stays stable
//   even if d_i moves.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en_i         offer a word this cycle (controller is in its output state)
//   ready_i      consumer ready
//   d_i          fresh word to offer
//   valid_o      word valid
//   data_o       offered word (0 when not offering)
module cpu_boot_dump_sreg
    import cpu_boot_pkg::*;
#(
    parameter int unsigned W = DW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         ready_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         held_q;   // word already captured, still waiting for ready
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= 1'b0;
            data_q <= '0;
        end else begin
            held_q <= en_i & ~ready_i;
            if (en_i && !held_q)
                data_q <= d_i;
        end
    end

    assign valid_o = en_i;
    assign data_o  = !en_i ? '0 : (held_q ? data_q : d_i);

endmodule

// File: rtl/cpu_boot_monitor.sv
// cpu_boot_monitor
//   Boot-and-dump controller for the cpu_32 family. A session loads a stream
//   of instruction words into CPU memory from address 0 (CPU held stopped),
//   releases the CPU until it reports HALTED or a run-cycle limit expires,
//   then streams the first NREG register values out over valid/ready.
//
//   Optional build macro CPU_BOOT_MONITOR_CYCLES_EN: after the last register
//   one extra word carrying the run cycle count is streamed with
//   out_idx = all-ones.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       pulse; begins a session from IDLE or DONE
//   in_valid/in_ready/in_data/in_last   load word stream
//   mem_we/mem_addr/mem_wdata   registered memory write port
//   cpu_run, cpu_halted         CPU enable / HALTED flag
//   reg_raddr, reg_rdata        register read (data one cycle after address)
//   out_valid/out_ready/out_data/out_idx  dump stream
//   done, timeout, load_count   session status
module cpu_boot_monitor
    import cpu_boot_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned RW   = RW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned TMO  = TMO_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_run,
    input  logic          cpu_halted,
    output logic [RW-1:0] reg_raddr,
    input  logic [DW-1:0] reg_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_idx,
    output logic          done,
    output logic          timeout,
    output logic [AW:0]   load_count
);

    // Run counter holds 0..TMO; after RUN it is frozen at the run length.
    localparam int unsigned CW = cnt_w(TMO);

    state_e        state_q, state_d;
    logic [AW:0]   load_cnt_q, load_cnt_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic          tmo_q, tmo_d;
    logic [RW-1:0] idx_q, idx_d;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          accept;
    logic          last_slot;
    logic          out_hs;
    logic [DW-1:0] dump_word;

`ifdef CPU_BOOT_MONITOR_CYCLES_EN
    logic          xtra_q, xtra_d;   // currently dumping the cycle-count word
`endif

    // Loading stops for good once the memory is full, even without in_last.
    assign in_ready  = (state_q == ST_LOAD) && !load_cnt_q[AW];
    assign accept    = in_valid & in_ready;
    assign last_slot = (load_cnt_q[AW-1:0] == {AW{1'b1}});
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        run_cnt_d  = run_cnt_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
`ifdef CPU_BOOT_MONITOR_CYCLES_EN
        xtra_d     = xtra_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                    tmo_d      = 1'b0;
                    idx_d      = '0;
`ifdef CPU_BOOT_MONITOR_CYCLES_EN
                    xtra_d     = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (in_last || last_slot) begin
                        state_d   = ST_RUN;
                        run_cnt_d = '0;
                    end
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                // HALTED takes priority over a limit hit in the same cycle.
                if (cpu_halted) begin
                    state_d = ST_DREQ;
                    tmo_d   = 1'b0;
                end else if (run_cnt_q == CW'(TMO - 1)) begin
                    state_d = ST_DREQ;
                    tmo_d   = 1'b1;
                end
            end
            ST_DREQ: begin
                state_d = ST_DOUT;
            end
            ST_DOUT: begin
                if (out_hs) begin
`ifdef CPU_BOOT_MONITOR_CYCLES_EN
                    if (xtra_q) begin
                        state_d = ST_DONE;
                    end else if (idx_q == RW'(NREG - 1)) begin
                        // Route through DREQ so throughput stays one per 2 cycles.
                        xtra_d  = 1'b1;
                        state_d = ST_DREQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DREQ;
                    end
`else
                    if (idx_q == RW'(NREG - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DREQ;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= '0;
            run_cnt_q   <= '0;
            tmo_q       <= 1'b0;
            idx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            run_cnt_q  <= run_cnt_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            mem_we_q   <= accept;
            if (accept) begin
                mem_addr_q  <= load_cnt_q[AW-1:0];
                mem_wdata_q <= in_data;
            end
        end
    end

`ifdef CPU_BOOT_MONITOR_CYCLES_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xtra_q <= 1'b0;
        else        xtra_q <= xtra_d;
    end

    assign dump_word = xtra_q ? DW'(run_cnt_q) : reg_rdata;
    assign out_idx   = !out_valid ? '0 : (xtra_q ? {RW{1'b1}} : idx_q);
`else
    assign dump_word = reg_rdata;
    assign out_idx   = out_valid ? idx_q : '0;
`endif

    cpu_boot_dump_sreg #(.W(DW)) u_dump_sreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == ST_DOUT),
        .ready_i (out_ready),
        .d_i     (dump_word),
        .valid_o (out_valid),
        .data_o  (out_data)
    );

    // State-decoded controls: these fall the instant reset asserts.
    assign cpu_run    = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign timeout    = tmo_q;
    assign load_count = load_cnt_q;
    assign reg_raddr  = idx_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cpu_boot_monitor.sv
module tb_cpu_boot_monitor;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int RW    = 5;
    localparam int NREG  = 10;
    localparam int TMO   = 750;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, cpu_halted = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0, reg_rdata = '0;
    logic          in_ready, mem_we, cpu_run, out_valid, done, timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, out_data;
    logic [RW-1:0] reg_raddr, out_idx;
    logic [AW:0]   load_count;

    cpu_boot_monitor #(.DW(DW), .AW(AW), .RW(RW), .NREG(NREG), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .done(done), .timeout(timeout), .load_count(load_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] regs [1<<RW];
    logic [DW-1:0] prog [16];
    int            wr_addr [$];
    logic [DW-1:0] wr_data [$];

    // Register file: data one cycle after address.
    always @(posedge clk) reg_rdata <= regs[reg_raddr];

    // Memory write log.
    always @(negedge clk) if (mem_we === 1'b1) begin
        wr_addr.push_back(int'(mem_addr));
        wr_data.push_back(mem_wdata);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full session. halt_at: run cycle in which HALTED is raised (0 = never).
    task automatic session(input int n, input bit use_last, input int halt_at,
                           input int ready_pct, input bit bubbles);
        int  exp_acc, exp_len, exp_n, acc, rc, cyc, k, last_hs, early;
        bit  exp_to, halted_case, stalled;
        logic [DW-1:0] hold_d;
        logic [RW-1:0] hold_i;
        int            exp_idx [$];
        logic [DW-1:0] exp_dat [$];

        exp_acc     = (n < DEPTH) ? n : DEPTH;
        halted_case = (halt_at > 0) && (halt_at <= TMO);
        exp_len     = halted_case ? halt_at : TMO;
        exp_to      = !halted_case;
        for (int j = 0; j < NREG; j++) begin
            exp_idx.push_back(j);
            exp_dat.push_back(regs[j]);
        end
`ifdef CPU_BOOT_MONITOR_CYCLES_EN
        exp_idx.push_back((1 << RW) - 1);
        exp_dat.push_back(DW'(exp_len));
`endif
        exp_n = exp_idx.size();
        wr_addr.delete();
        wr_data.delete();

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("load_count_clr", load_count, 0);
        chk("timeout_clr", timeout, 0);

        // Load phase
        acc = 0; cyc = 0; early = 0;
        while (cyc < 200 && in_ready === 1'b1) begin
            if (cpu_run !== 1'b0) early++;
            if (acc < n && !(bubbles && $urandom_range(3) == 0)) begin
                in_valid = 1'b1;
                in_data  = prog[acc];
                in_last  = use_last && (acc == n - 1);
                acc++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk); cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("load_bounded", cyc < 200, 1);
        chk("run_early", early, 0);
        chk("accepted", acc, exp_acc);
        chk("load_count", load_count, exp_acc);
        chk("run_rise", cpu_run, 1);
        chk("in_ready_low", in_ready, 0);

        // Run phase
        rc = 0; cyc = 0;
        while (cpu_run === 1'b1 && cyc < 2000) begin
            rc++;
            if (rc == halt_at) cpu_halted = 1'b1;
            @(negedge clk); cyc++;
        end
        cpu_halted = 1'b0;
        chk("run_len", rc, exp_len);
        chk("timeout", timeout, exp_to);

        chk("n_writes", wr_addr.size(), exp_acc);
        for (int j = 0; j < exp_acc && j < wr_addr.size(); j++) begin
            chk("wr_addr", wr_addr[j], j);
            chk("wr_data", wr_data[j], prog[j]);
        end

        // Dump phase
        k = 0; cyc = 0; stalled = 1'b0; last_hs = -10;
        hold_d = '0; hold_i = '0;
        while (done !== 1'b1 && cyc < 5000) begin
            if (out_valid === 1'b1) begin
                if (stalled) begin
                    chk("hold_data", out_data, hold_d);
                    chk("hold_idx", out_idx, hold_i);
                end
                out_ready = ($urandom_range(99) < ready_pct);
                if (out_ready) begin
                    if (k < exp_n) begin
                        chk("dump_idx", out_idx, exp_idx[k]);
                        chk("dump_data", out_data, exp_dat[k]);
                    end
                    if (ready_pct == 100 && k > 0) chk("dump_gap", cyc - last_hs, 2);
                    last_hs = cyc;
                    k++;
                end
                stalled = !out_ready;
                hold_d  = out_data;
                hold_i  = out_idx;
            end else begin
                if (stalled) chk("valid_drop", 0, 1);
                stalled   = 1'b0;
                out_ready = 1'($urandom_range(1));
            end
            @(negedge clk); cyc++;
        end
        out_ready = 1'b0;
        chk("dump_count", k, exp_n);
        chk("done", done, 1);
        chk("timeout_done", timeout, exp_to);
        chk("cpu_run_done", cpu_run, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int j = 0; j < (1 << RW); j++) regs[j] = DW'(j);
        prog[0] = 32'h00222000; prog[1] = 32'h04413800; prog[2] = 32'h2021FFFF;
        prog[3] = 32'h19020000; prog[4] = 32'hFC000000;
        for (int j = 5; j < 16; j++) prog[j] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_reg_raddr", reg_raddr, 0);
        chk("rst_out", {out_valid, out_data, out_idx}, 0);
        chk("rst_status", {done, timeout, load_count}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // Directed boot program, HALTED 20 cycles in, regs return k.
        session(5, 1'b1, 20, 100, 1'b0);

        // Random program, never halts -> timeout, random backpressure.
        for (int j = 0; j < (1 << RW); j++) regs[j] = $urandom;
        for (int j = 0; j < 16; j++) prog[j] = $urandom;
        session(3, 1'b1, 0, 50, 1'b1);

        // Reset while in DONE.
        @(negedge clk); #2 rst_n = 1'b0; #1;
        chk("rst_done", done, 0);
        chk("rst_done_tmo", timeout, 0);
        @(negedge clk); rst_n = 1'b1;

        // Reset during RUN, then a clean 1-word session.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_data = prog[0]; in_last = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        chk("pre_rst_run", cpu_run, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0; #1;
        chk("rst_run_cpu_run", cpu_run, 0);
        chk("rst_run_out_valid", out_valid, 0);
        chk("rst_run_done", done, 0);
        chk("rst_run_load_count", load_count, 0);
        @(negedge clk); rst_n = 1'b1;
        session(1, 1'b1, $urandom_range(1, 40), 70, 1'b0);

        // Overflow without in_last; HALTED on the limit cycle (halt wins).
        for (int j = 0; j < 16; j++) prog[j] = $urandom;
        session(10, 1'b0, TMO, 30, 1'b1);

        // Random sessions.
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < (1 << RW); j++) regs[j] = $urandom;
            for (int j = 0; j < 16; j++) prog[j] = $urandom;
            session($urandom_range(1, DEPTH), 1'b1, $urandom_range(1, 60),
                    $urandom_range(20, 100), 1'b1);
        end

        // HALTED one cycle too late -> timeout.
        session(2, 1'b1, TMO + 1, 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_boot_monitor.md
Name: cpu_boot_monitor

Overview:
- Synthesizable boot-and-dump controller for the cpu_32 family.
- Accepts a stream of instruction words and writes them into CPU memory from address 0, holding the CPU stopped while loading.
- Releases the CPU, then waits for HALTED or a cycle timeout.
- Streams the first NREG register values out over a valid/ready port.
- Generalises data width, memory depth, register count and timeout.

Parameters:
DW, 32, data/instruction word width
AW, 10, memory address width (depth 2**AW)
RW, 5, register-file address width
NREG, 10, registers dumped (1..2**RW)
TMO, 750, max run cycles before timeout (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a session from IDLE or DONE
in_valid  in  1  load word valid
in_ready  out  1  load word accepted when in_valid&in_ready
in_data  in  DW  instruction word
in_last  in  1  marks final load word
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory write address
mem_wdata  out  DW  memory write data
cpu_run  out  1  CPU enable; PC held at 0 while low
cpu_halted  in  1  CPU HALTED flag
reg_raddr  out  RW  register read address
reg_rdata  in  DW  register data, valid one cycle after reg_raddr
out_valid  out  1  dump word valid
out_ready  in  1  dump consumer ready
out_data  out  DW  dumped register value
out_idx  out  RW  register index of out_data
done  out  1  session finished (level)
timeout  out  1  run ended by timeout (level)
load_count  out  AW+1  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (in_ready, mem_we, cpu_run, out_valid, done, timeout, load_count, addresses, data).
- States: IDLE→LOAD→RUN→DREQ→DOUT→DONE.
- IDLE: in_ready=0. start → LOAD. Clear load_count, done and timeout.
- LOAD: in_ready=1.
  - Each accepted word drives mem_we=1, mem_addr=load_count[AW-1:0] and mem_wdata=in_data registered (writes 1 cycle after accept); load_count increments.
  - Accept with in_last → RUN; in_ready drops the next cycle.
  - Overflow: if load_count reaches 2**AW without in_last → RUN, with in_ready forced 0. Further words are never accepted.
- RUN: cpu_run=1; cycle counter starts at 0.
  - cpu_halted=1 → DREQ, timeout=0.
  - Counter reaches TMO-1 without halt → DREQ, timeout=1.
  - If halted and the limit hit in the same cycle, halted wins (timeout=0).
  - cpu_run drops on the cycle DREQ is entered.
- DREQ: drive reg_raddr=idx (idx starts at 0); next cycle → DOUT.
- DOUT: capture reg_rdata into out_data, out_idx=idx, out_valid=1.
  - Hold out_data and out_idx stable while out_valid&!out_ready.
  - On handshake: idx++. If idx==NREG-1 → DONE, else → DREQ.
  - Throughput: one word per 2 cycles max.
- DONE: done=1, timeout held. start → LOAD as a new session (in IDLE/DONE only; ignored elsewhere).
- Reset mid-session: immediate IDLE; cpu_run=0 asynchronously. No partial dump resumes.

Optional Feature:
- Macro: CPU_BOOT_MONITOR_CYCLES_EN.
- Defined: after the last register, one extra word is streamed with out_data=run cycle count (zero-extended/truncated to DW) and out_idx=all-ones. It completes its own handshake, then → DONE.
- Undefined: exactly NREG words; no cycle-count logic is synthesised.

Decomposition:
- Package cpu_boot_pkg holds:
  - state enum encoding (IDLE=0, LOAD=1, RUN=2, DREQ=3, DOUT=4, DONE=5, 3 bits);
  - default width constants DW/AW/RW.
- One natural sub-module: cpu_boot_dump_sreg, the DOUT output holding register implementing valid/ready hold with a capture enable. The rest stays flat.

Test Plan:
- Load 5 words (0x00222000, 0x04413800, 0x2021FFFF, 0x19020000, 0xFC000000; last on 5th) with in_valid held high → mem writes at addr 0..4 with matching data; load_count=5; cpu_run rises the cycle after the 5th accept.
- cpu_halted asserted 20 cycles into RUN, out_ready=1, register model returns k for reg k → 10 dump words, out_data=out_idx=0..9, every other cycle; done=1, timeout=0.
- cpu_halted never asserted, TMO=750 → cpu_run high for exactly 750 cycles; timeout=1; full dump still occurs.
- out_ready toggled randomly during dump → no word lost or duplicated; out_data stable while stalled; sequence 0..9.
- AW=3, 10 words, no in_last → exactly 8 writes (addr 0..7); in_ready=0 after the 8th; RUN entered.
- rst_n pulsed low during RUN → cpu_run, out_valid and done go 0 immediately. A following start plus a 1-word load runs a clean session with load_count=1.
